// File: rtl/sbox_ddt_row_scanner.sv
// rtl/sbox_ddt_row_scanner.sv - one DDT row of a 6-bit S-box, histogrammed and streamed out with its maximum
module sbox_ddt_row_scanner #(
    parameter int N     = 6,
    parameter int CNT_W = N + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     delta,
    output logic             busy,
    output logic [N-1:0]     sbox_a,
    output logic [N-1:0]     sbox_b,
    input  logic [N-1:0]     sbox_ya,
    input  logic [N-1:0]     sbox_yb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_idx,
    output logic [CNT_W-1:0] out_count,
    output logic             out_last,
    output logic [CNT_W-1:0] row_max,
    output logic             done
);

    localparam int          DEPTH = 1 << N;
    localparam logic [N-1:0] LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SCAN,
        S_FLUSH,
        S_DRAIN
    } state_t;

    state_t state, state_nxt;

    logic [N-1:0]     delta_q;
    logic [N-1:0]     x_q;
    logic [N-1:0]     b_q;
    logic [N-1:0]     d_q;
    logic             d_valid_q;
    logic [CNT_W-1:0] cnt [DEPTH];
    logic             accept;

    assign accept = out_valid & out_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = S_SCAN;
            S_SCAN:  if (x_q == LAST) state_nxt = S_FLUSH;
            S_FLUSH: state_nxt = S_DRAIN;
            S_DRAIN: if (accept && (b_q == LAST)) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            delta_q   <= '0;
            x_q       <= '0;
            b_q       <= '0;
            d_q       <= '0;
            d_valid_q <= 1'b0;
            row_max   <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            done      <= 1'b0;
            d_valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) delta_q <= delta;
                end
                S_CLEAR: begin
                    x_q     <= '0;
                    b_q     <= '0;
                    row_max <= '0;
                end
                S_SCAN: begin
                    // Stage 1: capture the output difference; x wraps to 0 after the last input
                    d_q       <= sbox_ya ^ sbox_yb;
                    d_valid_q <= 1'b1;
                    x_q       <= x_q + 1'b1;
                end
                S_DRAIN: begin
                    if (accept) begin
                        if (cnt[b_q] > row_max) row_max <= cnt[b_q];
                        b_q <= b_q + 1'b1;
                        if (b_q == LAST) done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage 2 histogram; CLEAR initialises the counters, so they carry no reset
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            for (int i = 0; i < DEPTH; i++) cnt[i] <= '0;
        end else if (d_valid_q) begin
            cnt[d_q] <= cnt[d_q] + 1'b1;
        end
    end

    assign busy      = (state != S_IDLE);
    assign sbox_a    = (state == S_SCAN) ? x_q : '0;
    assign sbox_b    = (state == S_SCAN) ? (x_q ^ delta_q) : '0;
    assign out_valid = (state == S_DRAIN);
    assign out_idx   = (state == S_DRAIN) ? b_q : '0;
    assign out_count = (state == S_DRAIN) ? cnt[b_q] : '0;
    assign out_last  = (state == S_DRAIN) && (b_q == LAST);

endmodule

// File: tb/tb_sbox_ddt_row_scanner.sv
// tb/tb_sbox_ddt_row_scanner.sv - randomized self-checking bench against a software DDT row model
module tb_sbox_ddt_row_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [5:0] delta = '0;
    logic       busy;
    logic [5:0] sbox_a, sbox_b, sbox_ya, sbox_yb;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [5:0] out_idx;
    logic [6:0] out_count;
    logic       out_last;
    logic [6:0] row_max;
    logic       done;

    int vec  = 0;
    int errs = 0;
    int mode = 0;
    logic [5:0] perm [64];
    int exp_cnt [64];
    int exp_max;

    sbox_ddt_row_scanner #(.N(6), .CNT_W(7)) dut (
        .clk(clk), .rst(rst), .start(start), .delta(delta), .busy(busy),
        .sbox_a(sbox_a), .sbox_b(sbox_b), .sbox_ya(sbox_ya), .sbox_yb(sbox_yb),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_count(out_count), .out_last(out_last), .row_max(row_max), .done(done)
    );

    always #5 clk = ~clk;

    // GF(2^6) with x^6 + x + 1; the cube map stands in for a power-map S-box
    function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] p;
        logic [5:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 6; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[5] ? ((aa << 1) ^ 6'h03) : (aa << 1);
        end
        return p;
    endfunction

    function automatic logic [5:0] sbox_ref(input int m, input logic [5:0] x);
        case (m)
            0:       return x;
            1:       return gf_mul(gf_mul(x, x), x);
            default: return perm[x];
        endcase
    endfunction

    always_comb begin
        sbox_ya = sbox_ref(mode, sbox_a);
        sbox_yb = sbox_ref(mode, sbox_b);
    end

    task automatic compute_model(input logic [5:0] dl);
        logic [5:0] x;
        for (int i = 0; i < 64; i++) exp_cnt[i] = 0;
        for (int i = 0; i < 64; i++) begin
            x = 6'(i);
            exp_cnt[sbox_ref(mode, x) ^ sbox_ref(mode, x ^ dl)] += 1;
        end
        exp_max = 0;
        for (int i = 0; i < 64; i++) if (exp_cnt[i] > exp_max) exp_max = exp_cnt[i];
    endtask

    task automatic run_row(input logic [5:0] dl, input bit rnd_ready, input bit inject, input bit abort);
        int n, b, guard, stall, sum;
        bit r;
        logic [6:0] seen;
        compute_model(dl);
        @(negedge clk);
        delta = dl;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        delta = ~dl;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (n >= 1 && n <= 64) begin
                vec++;
                if (sbox_a !== 6'(n-1) || sbox_b !== (6'(n-1) ^ dl)) begin
                    errs++;
                    $display("FAIL scan_drive x=%0d: sbox_a=%h sbox_b=%h expected %h %h", n-1, sbox_a, sbox_b, 6'(n-1), 6'(n-1) ^ dl);
                end
            end
            if (inject && n == 30) begin start = 1'b1; delta = dl ^ 6'h2a; end
            if (inject && n == 31) start = 1'b0;
            if (abort && n == 41) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                vec++;
                if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || sbox_a !== 6'h0) begin
                    errs++;
                    $display("FAIL abort_reset: busy=%b out_valid=%b done=%b sbox_a=%h expected 0 0 0 00", busy, out_valid, done, sbox_a);
                end
                for (int k = 0; k < 5; k++) begin
                    @(posedge clk); #1;
                    vec++;
                    if (done !== 1'b0 || busy !== 1'b0) begin
                        errs++;
                        $display("FAIL abort_quiet: done=%b busy=%b expected 0 0", done, busy);
                    end
                end
                return;
            end
        end
        vec++;
        if (n !== 66) begin
            errs++;
            $display("FAIL latency: first out_valid after %0d cycles, expected 66", n);
        end
        b = 0; guard = 0; stall = 0; sum = 0;
        while (b < 64 && guard < 3000) begin
            guard++;
            vec++;
            if (out_valid !== 1'b1 || out_idx !== 6'(b) || out_count !== 7'(exp_cnt[b]) || out_last !== (b == 63)
                || (dl != 0 && out_count[0] !== 1'b0)) begin
                errs++;
                $display("FAIL drain b=%0d: valid=%b idx=%0d count=%0d last=%b expected 1 %0d %0d %b",
                         b, out_valid, out_idx, out_count, out_last, b, exp_cnt[b], b == 63);
            end
            seen = out_count;
            r = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rnd_ready && b == 31 && stall < 10) begin r = 1'b0; stall++; end
            if (inject && b == 10) begin start = 1'b1; delta = dl ^ 6'h01; end
            else start = 1'b0;
            out_ready = r;
            @(posedge clk); #1;
            if (r) begin sum += int'(seen); b++; end
        end
        start = 1'b0;
        out_ready = 1'b0;
        vec++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL done_pulse: done=%b out_valid=%b busy=%b expected 1 0 0", done, out_valid, busy);
        end
        vec++;
        if (row_max !== 7'(exp_max)) begin
            errs++;
            $display("FAIL row_max: got %0d expected %0d", row_max, exp_max);
        end
        vec++;
        if (sum != 64) begin
            errs++;
            $display("FAIL row_sum: got %0d expected 64", sum);
        end
        @(posedge clk); #1;
        vec++;
        if (done !== 1'b0 || row_max !== 7'(exp_max)) begin
            errs++;
            $display("FAIL done_once: done=%b row_max=%0d expected 0 %0d", done, row_max, exp_max);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vec++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || done !== 1'b0) begin
            errs++;
            $display("FAIL reset_flags: busy=%b valid=%b last=%b done=%b expected 0 0 0 0", busy, out_valid, out_last, done);
        end
        vec++;
        if (sbox_a !== 6'h0 || sbox_b !== 6'h0 || out_idx !== 6'h0 || out_count !== 7'h0 || row_max !== 7'h0) begin
            errs++;
            $display("FAIL reset_data: a=%h b=%h idx=%h count=%h max=%h expected zeros", sbox_a, sbox_b, out_idx, out_count, row_max);
        end
        rst = 1'b0;
    endtask

    task automatic test_identity;
        mode = 0;
        run_row(6'h15, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_delta_zero;
        mode = 1;
        run_row(6'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_power_map;
        mode = 1;
        run_row(6'h01, 1'b0, 1'b0, 1'b0);
        run_row(6'(1 + $urandom_range(0, 62)), 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure;
        mode = 2;
        run_row(6'($urandom_range(1, 63)), 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_scan;
        mode = 1;
        run_row(6'h0b, 1'b0, 1'b0, 1'b1);
        run_row(6'h0b, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_start_ignored;
        mode = 2;
        run_row(6'h22, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) begin
            mode = i % 3;
            run_row(6'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [5:0] t;
        int j;
        for (int i = 0; i < 64; i++) perm[i] = 6'(i);
        for (int i = 63; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = perm[i];
            perm[i] = perm[j];
            perm[j] = t;
        end
        test_reset;
        test_identity;
        test_delta_zero;
        test_power_map;
        test_backpressure;
        test_reset_mid_scan;
        test_start_ignored;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
